// File: rtl/dca_matrix_lsu_read_path.sv
// Matrix LSU read path: turns walker txn info into LPIXM read requests and
// forwards read-response beats to the consumer with per-burst last marking.
//
// state | meaning
// IDLE  | waiting for a READ instruction
// ISSUE | accepting txn info, issuing read requests
// DRAIN | all txns taken; waiting for requests and bursts to finish
// DONE  | one-cycle completion pulse
module dca_matrix_lsu_read_path #(
    parameter int BW_ADDR                        = 32,
    parameter int BW_DATA                        = 32,
    parameter int BW_BITADDR                     = 35,
    parameter int BW_ALEN                        = 8,
    parameter int BW_LPI_BURDEN                  = 1,
    parameter int MAX_OUTSTANDING                = 4,
    parameter int BW_DCA_MATRIX_LSU_INST_OPCODE  = 3,
    parameter int DCA_MATRIX_LSU_INST_OPCODE_READ = 1
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       inst_valid,
    input  logic [BW_DCA_MATRIX_LSU_INST_OPCODE-1:0]   inst_opcode,
    input  logic                                       txn_valid,
    output logic                                       txn_ready,
    input  logic [BW_BITADDR-1:0]                      txn_bitaddr,
    input  logic [BW_ALEN-1:0]                         txn_alen,
    input  logic                                       txn_skip,
    input  logic                                       txn_last,
    input  logic [BW_LPI_BURDEN-1:0]                   burden_in,
    output logic                                       req_valid,
    input  logic                                       req_ready,
    output logic [BW_LPI_BURDEN+BW_ALEN+BW_ADDR+5:0]   req_qdata,
    input  logic                                       rsp_valid,
    output logic                                       rsp_ready,
    input  logic [BW_DATA-1:0]                         rsp_data,
    input  logic [1:0]                                 rsp_resp,
    output logic                                       rdata_valid,
    input  logic                                       rdata_ready,
    output logic [BW_DATA-1:0]                         rdata,
    output logic                                       rdata_last,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       error
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam logic [2:0] ASIZE = 3'($clog2(BW_DATA / 8));
    localparam logic [BW_ADDR-1:0] ADDR_MASK = ~BW_ADDR'((1 << ASIZE) - 1);
    localparam logic [BW_DCA_MATRIX_LSU_INST_OPCODE-1:0] OPC_READ =
        BW_DCA_MATRIX_LSU_INST_OPCODE'(DCA_MATRIX_LSU_INST_OPCODE_READ);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [BW_ALEN-1:0] beat;
    logic [BW_ALEN-1:0] len_fifo [MAX_OUTSTANDING];

    logic               start;
    logic               txn_acc;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic               beat_hs;
    logic               stray;
    logic               err_set;
    logic [BW_ADDR-1:0] txn_addr;
    logic               unused_bits;

    assign fifo_empty = (count == '0);
    assign start      = (state == IDLE) & inst_valid & (inst_opcode == OPC_READ);
    assign txn_ready  = (state == ISSUE) & (~req_valid | req_ready)
                      & (count < CNT_W'(MAX_OUTSTANDING));
    assign txn_acc    = txn_valid & txn_ready;
    assign push       = txn_acc & ~txn_skip;

    // Byte address of the burst, aligned down to the data-bus width.
    assign txn_addr    = txn_bitaddr[BW_ADDR+2:3] & ADDR_MASK;
    assign unused_bits = ^txn_bitaddr[2:0];

    // Beats arriving with no burst outstanding are swallowed and flagged.
    assign rdata_valid = rsp_valid & ~fifo_empty;
    assign rsp_ready   = fifo_empty ? rsp_valid : rdata_ready;
    assign rdata       = rsp_data;
    assign rdata_last  = rdata_valid & (beat == len_fifo[rd_ptr]);
    assign beat_hs     = rdata_valid & rdata_ready;
    assign pop         = beat_hs & rdata_last;
    assign stray       = rsp_valid & fifo_empty;
    assign err_set     = (beat_hs & (rsp_resp != 2'b00)) | stray;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            len_fifo[wr_ptr] <= txn_alen;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            beat      <= '0;
            req_valid <= 1'b0;
            req_qdata <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (beat_hs) begin
                beat <= pop ? '0 : beat + BW_ALEN'(1);
            end
            // A new accept may overwrite the request on its handshake edge.
            if (push) begin
                req_valid <= 1'b1;
                req_qdata <= {burden_in, 1'b0, txn_alen, ASIZE, 2'b01, txn_addr};
            end else if (req_ready) begin
                req_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                error <= 1'b0;
            end
            if (err_set) begin
                error <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (txn_acc && txn_last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_empty && !req_valid) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
